// File: rtl/fix_mult_pkg.sv
// Shared definitions for the sequential fixed-point multiplier: FSM state
// codes, iteration count and saturation limits.
package fix_mult_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Wide enough to hold saturation limits for any output up to 128 bits.
  localparam int SAT_W = 130;
  typedef logic signed [SAT_W-1:0] sat_t;

  function automatic int iter_count(input int input_width, input int bits_per_cycle);
    return input_width / bits_per_cycle;
  endfunction

  function automatic sat_t sat_max(input int out_width, input bit is_signed);
    sat_t one;
    one = sat_t'(1);
    return is_signed ? (one <<< (out_width - 1)) - one : (one <<< out_width) - one;
  endfunction

  function automatic sat_t sat_min(input int out_width, input bit is_signed);
    sat_t one;
    one = sat_t'(1);
    return is_signed ? -(one <<< (out_width - 1)) : '0;
  endfunction

endpackage

// File: rtl/fix_round_sat.sv
// Combinational rescale, optional round-half-up and saturation of a full
// fixed-point product. Rounding is enabled by defining FIX_MULT_ROUND_EN.
module fix_round_sat
  import fix_mult_pkg::*;
#(
  parameter int PROD_WIDTH   = 32,
  parameter int FRAC_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SIGNED       = 1
) (
  input  logic [PROD_WIDTH-1:0]   product,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow
);

  localparam sat_t MAX_V = sat_max(OUTPUT_WIDTH, SIGNED != 0);
  localparam sat_t MIN_V = sat_min(OUTPUT_WIDTH, SIGNED != 0);

  logic signed [PROD_WIDTH:0] extended;
  logic signed [PROD_WIDTH:0] rounded;
  logic signed [PROD_WIDTH:0] scaled;
  sat_t                       wide;

  // One guard bit so the rounding add and unsigned products never wrap.
  assign extended = (SIGNED != 0) ? {product[PROD_WIDTH-1], product} : {1'b0, product};

`ifdef FIX_MULT_ROUND_EN
  if (FRAC_WIDTH > 0) begin : g_round
    localparam logic signed [PROD_WIDTH:0] HALF_LSB = (PROD_WIDTH + 1)'(1) <<< (FRAC_WIDTH - 1);
    assign rounded = extended + HALF_LSB;
  end else begin : g_no_round
    assign rounded = extended;
  end
`else
  assign rounded = extended;
`endif

  assign scaled = rounded >>> FRAC_WIDTH;
  assign wide   = sat_t'(scaled);

  always_comb begin
    result   = scaled[OUTPUT_WIDTH-1:0];
    overflow = 1'b0;
    if (wide > MAX_V) begin
      result   = MAX_V[OUTPUT_WIDTH-1:0];
      overflow = 1'b1;
    end else if (wide < MIN_V) begin
      result   = MIN_V[OUTPUT_WIDTH-1:0];
      overflow = 1'b1;
    end
  end

endmodule

// File: rtl/fix_mult_seq.sv
// Sequential sign-magnitude shift-add fixed-point multiplier with valid/ready
// handshakes. Define FIX_MULT_ROUND_EN for round-half-up instead of truncation.
module fix_mult_seq
  import fix_mult_pkg::*;
#(
  parameter int INPUT_WIDTH    = 16,
  parameter int FRAC_WIDTH     = 8,
  parameter int OUTPUT_WIDTH   = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  multiplicand,
  input  logic [INPUT_WIDTH-1:0]  multiplier,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow
);

  localparam int N  = iter_count(INPUT_WIDTH, BITS_PER_CYCLE);
  localparam int PW = 2 * INPUT_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  if (FRAC_WIDTH < 0 || FRAC_WIDTH >= INPUT_WIDTH) begin : g_bad_frac
    $error("fix_mult_seq: FRAC_WIDTH must satisfy 0 <= FRAC_WIDTH < INPUT_WIDTH");
  end
  if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH > PW) begin : g_bad_out
    $error("fix_mult_seq: OUTPUT_WIDTH must be in 1..2*INPUT_WIDTH");
  end
  if (BITS_PER_CYCLE < 1 || (INPUT_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("fix_mult_seq: BITS_PER_CYCLE must divide INPUT_WIDTH");
  end

  logic [1:0]             state;
  logic [PW-1:0]          addend;
  logic [INPUT_WIDTH-1:0] mag_b;
  logic                   sign;
  logic [PW-1:0]          acc;
  logic [CW-1:0]          cnt;

  logic [INPUT_WIDTH-1:0]  abs_a;
  logic [INPUT_WIDTH-1:0]  abs_b;
  logic                    sign_in;
  logic [PW-1:0]           partial;
  logic [PW-1:0]           signed_prod;
  logic [OUTPUT_WIDTH-1:0] result_d;
  logic                    overflow_d;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    abs_a   = multiplicand;
    abs_b   = multiplier;
    sign_in = 1'b0;
    if (SIGNED != 0) begin
      if (multiplicand[INPUT_WIDTH-1]) abs_a = -multiplicand;
      if (multiplier[INPUT_WIDTH-1])   abs_b = -multiplier;
      sign_in = multiplicand[INPUT_WIDTH-1] ^ multiplier[INPUT_WIDTH-1];
    end
  end

  // The addend is pre-shifted each iteration, so no variable shifter is needed.
  assign partial     = addend * PW'(mag_b[BITS_PER_CYCLE-1:0]);
  assign signed_prod = sign ? -acc : acc;
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);

  fix_round_sat #(
    .PROD_WIDTH   (PW),
    .FRAC_WIDTH   (FRAC_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .SIGNED       (SIGNED)
  ) u_round_sat (
    .product  (signed_prod),
    .result   (result_d),
    .overflow (overflow_d)
  );

  // Finalisation uses the registered accumulator, keeping round/saturate off the adder path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addend   <= '0;
      mag_b    <= '0;
      sign     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            addend <= PW'(abs_a);
            mag_b  <= abs_b;
            sign   <= sign_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == LAST) begin
            result   <= result_d;
            overflow <= overflow_d;
            state    <= DONE;
          end else begin
            acc    <= acc + partial;
            addend <= addend << BITS_PER_CYCLE;
            mag_b  <= mag_b >> BITS_PER_CYCLE;
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_mult_seq.sv
// Self-checking bench for fix_mult_seq: Q8.8 signed bit-serial instance plus an
// unsigned 4-bits-per-cycle instance, checked against an arithmetic model.
module tb_fix_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;

  logic        in_ready_s, out_valid_s, overflow_s;
  logic [15:0] result_s;
  logic        in_ready_u, out_valid_u, overflow_u;
  logic [15:0] result_u;

  int errors = 0;
  int checks = 0;

`ifdef FIX_MULT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  always #5 clk = ~clk;

  fix_mult_seq dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready_s),
    .multiplicand (multiplicand), .multiplier (multiplier),
    .out_valid (out_valid_s), .out_ready (out_ready),
    .result (result_s), .overflow (overflow_s)
  );

  fix_mult_seq #(.BITS_PER_CYCLE(4), .SIGNED(0)) dut_u (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready_u),
    .multiplicand (multiplicand), .multiplier (multiplier),
    .out_valid (out_valid_u), .out_ready (out_ready),
    .result (result_u), .overflow (overflow_u)
  );

  // Reference: exact integer product, Q8 rescale, optional half-up round, clamp.
  function automatic void model(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic ov);
    longint p, mx, mn;
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'(a) * longint'(b);
    if (ROUND) p = p + 128;
    p  = p >>> 8;
    mx = sgn ? 32767 : 65535;
    mn = sgn ? -32768 : 0;
    ov = 1'b0;
    if (p > mx) begin p = mx; ov = 1'b1; end
    else if (p < mn) begin p = mn; ov = 1'b1; end
    r = p[15:0];
  endfunction

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit uns, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic ov, output int lat);
    int guard;
    guard = 0;
    while (!(uns ? in_ready_u : in_ready_s) && guard < 50) begin
      wait_edge();
      guard++;
    end
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    wait_edge();
    in_valid     = 1'b0;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    lat = 0;
    while (lat < 40) begin
      wait_edge();
      lat++;
      if (uns ? out_valid_u : out_valid_s) break;
    end
    r  = uns ? result_u : result_s;
    ov = uns ? overflow_u : overflow_s;
    wait_edge();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    multiplicand = '0; multiplier = '0;
    wait_edge();
    wait_edge();
    checks++; if (in_ready_s !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready_s); end
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid_s); end
    checks++; if (result_s !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0000", result_s); end
    checks++; if (overflow_s !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_s); end
    checks++; if (in_ready_u !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_u: got %b expected 1", in_ready_u); end
    rst = 1'b0;
    wait_edge();
  endtask

  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] r; logic ov; } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [15:0] r; logic ov; int lat;
    v.push_back('{16'h0180, 16'h0200, 16'h0300, 1'b0});
    v.push_back('{16'hFF00, 16'h0080, 16'hFF80, 1'b0});
    v.push_back('{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1});
    v.push_back('{16'h8000, 16'h8000, 16'h7FFF, 1'b1});
    v.push_back('{16'h8000, 16'h7FFF, 16'h8000, 1'b1});
    v.push_back('{16'h0001, 16'h0080, ROUND ? 16'h0001 : 16'h0000, 1'b0});
    v.push_back('{16'hFFFF, 16'h0080, ROUND ? 16'h0000 : 16'hFFFF, 1'b0});
    v.push_back('{16'h0000, 16'h1234, 16'h0000, 1'b0});
    v.push_back('{16'h5A5A, 16'h0000, 16'h0000, 1'b0});
    foreach (v[i]) begin
      run_op(1'b0, v[i].a, v[i].b, r, ov, lat);
      checks++; if (r !== v[i].r) begin errors++; $display("[TB] FAIL dir_result[%0d]: got %h expected %h", i, r, v[i].r); end
      checks++; if (ov !== v[i].ov) begin errors++; $display("[TB] FAIL dir_overflow[%0d]: got %b expected %b", i, ov, v[i].ov); end
      checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL dir_latency[%0d]: got %0d expected 17", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, r, er; logic ov, eov; int lat;
    logic [11:0] sa, sb;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        sa = 12'($urandom); sb = 12'($urandom);
        a = {{4{sa[11]}}, sa}; b = {{4{sb[11]}}, sb};
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
      model(1'b1, a, b, er, eov);
      run_op(1'b0, a, b, r, ov, lat);
      checks++; if (r !== er) begin errors++; $display("[TB] FAIL rand_result %h*%h: got %h expected %h", a, b, r, er); end
      checks++; if (ov !== eov) begin errors++; $display("[TB] FAIL rand_overflow %h*%h: got %b expected %b", a, b, ov, eov); end
      checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL rand_latency %h*%h: got %0d expected 17", a, b, lat); end
    end
  endtask

  task automatic test_backpressure();
    int guard, lat;
    logic [15:0] er; logic eov;
    guard = 0;
    while (!in_ready_s && guard < 50) begin wait_edge(); guard++; end
    multiplicand = 16'h0180; multiplier = 16'h0200;
    in_valid = 1'b1; out_ready = 1'b0;
    wait_edge();
    multiplicand = 16'h0100; multiplier = 16'h0300;
    guard = 0;
    while (!out_valid_s && guard < 40) begin wait_edge(); guard++; end
    checks++; if (out_valid_s !== 1'b1) begin errors++; $display("[TB] FAIL bp_reach_done: got %b expected 1", out_valid_s); end
    for (int i = 0; i < 5; i++) begin
      wait_edge();
      checks++; if (out_valid_s !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid_s); end
      checks++; if (result_s !== 16'h0300) begin errors++; $display("[TB] FAIL bp_hold_result[%0d]: got %h expected 0300", i, result_s); end
      checks++; if (in_ready_s !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready_s); end
    end
    out_ready = 1'b1;
    wait_edge();
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid_s); end
    checks++; if (in_ready_s !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready_s); end
    wait_edge();
    checks++; if (in_ready_s !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_accept: got %b expected 0", in_ready_s); end
    in_valid = 1'b0;
    model(1'b1, 16'h0100, 16'h0300, er, eov);
    lat = 0;
    while (lat < 40) begin
      wait_edge();
      lat++;
      if (out_valid_s) break;
    end
    checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL bp_next_latency: got %0d expected 17", lat); end
    checks++; if (result_s !== er) begin errors++; $display("[TB] FAIL bp_next_result: got %h expected %h", result_s, er); end
    wait_edge();
  endtask

  task automatic test_mid_reset();
    int guard; logic seen;
    logic [15:0] r; logic ov; int lat;
    guard = 0;
    while (!in_ready_s && guard < 50) begin wait_edge(); guard++; end
    multiplicand = 16'h7FFF; multiplier = 16'h7FFF; in_valid = 1'b1; out_ready = 1'b1;
    wait_edge();
    in_valid = 1'b0;
    repeat (6) wait_edge();
    rst = 1'b1;
    wait_edge();
    rst = 1'b0;
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("[TB] FAIL mrst_out_valid: got %b expected 0", out_valid_s); end
    checks++; if (in_ready_s !== 1'b1) begin errors++; $display("[TB] FAIL mrst_in_ready: got %b expected 1", in_ready_s); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_edge();
      if (out_valid_s) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL mrst_discarded: got out_valid %b expected 0", seen); end
    run_op(1'b0, 16'h0100, 16'h0100, r, ov, lat);
    checks++; if (r !== 16'h0100) begin errors++; $display("[TB] FAIL mrst_fresh_result: got %h expected 0100", r); end
    checks++; if (ov !== 1'b0) begin errors++; $display("[TB] FAIL mrst_fresh_overflow: got %b expected 0", ov); end
    checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL mrst_fresh_latency: got %0d expected 17", lat); end
  endtask

  task automatic test_unsigned_bpc4();
    logic [15:0] a, b, r, er; logic ov, eov; int lat;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
      else if (i == 1) begin a = 16'h0180; b = 16'h0200; end
      else if (i % 2 == 0) begin a = 16'($urandom_range(0, 4095)); b = 16'($urandom_range(0, 4095)); end
      else begin a = 16'($urandom); b = 16'($urandom); end
      model(1'b0, a, b, er, eov);
      run_op(1'b1, a, b, r, ov, lat);
      checks++; if (r !== er) begin errors++; $display("[TB] FAIL uns_result %h*%h: got %h expected %h", a, b, r, er); end
      checks++; if (ov !== eov) begin errors++; $display("[TB] FAIL uns_overflow %h*%h: got %b expected %b", a, b, ov, eov); end
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL uns_latency %h*%h: got %0d expected 5", a, b, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mid_reset();
    test_unsigned_bpc4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
